// File: rtl/seg7_display_ctrl_if.sv
// Handshake and display bus between a score/message source and the
// seven-segment sequencer. The master side offers scores and messages;
// the slave side (the sequencer) acknowledges them and drives the four
// decoder codes, with digit3 as the leftmost digit.
interface seg7_display_ctrl_if;
   logic        score_valid;
   logic [13:0] score;
   logic        score_ready;
   logic        msg_req;
   logic [1:0]  msg_sel;
   logic        msg_ack;
   logic        busy;
   logic [4:0]  digit3;
   logic [4:0]  digit2;
   logic [4:0]  digit1;
   logic [4:0]  digit0;

   modport master (
      output score_valid, score, msg_req, msg_sel,
      input  score_ready, msg_ack, busy, digit3, digit2, digit1, digit0
   );

   modport slave (
      input  score_valid, score, msg_req, msg_sel,
      output score_ready, msg_ack, busy, digit3, digit2, digit1, digit0
   );
endinterface

// File: rtl/seg7_display_ctrl.sv
// Four-digit seven-segment sequencer. It converts binary scores to decimal
// decoder codes by repeated subtraction, and overlays blinking text
// messages for a fixed hold time before the committed score returns.
module seg7_display_ctrl #(
   parameter int unsigned HOLD_CYCLES  = 50_000_000,
   parameter int unsigned BLINK_CYCLES = 12_500_000
) (
   input logic             clk,
   input logic             rst,
   seg7_display_ctrl_if.slave bus
);

   localparam int unsigned HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
   localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, CONV, SHOW_MSG} state_t;
   typedef enum logic [1:0] {PH_THOU, PH_HUND, PH_TENS} phase_t;
   typedef logic [3:0][4:0] digits_t;

   localparam digits_t RESET_DIGITS = {5'd31, 5'd31, 5'd31, 5'd0};

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [13:0] rem_q, rem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  d3c_q, d3c_d;
   logic [3:0]  d2c_q, d2c_d;
   digits_t     com_q, com_d;
   digits_t     dig_q, dig_d;
   digits_t     msg_q, msg_d;
   logic        vis_q, vis_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [BW-1:0] blink_q, blink_d;
   logic        ack_q, ack_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;

   logic        msg_take;
   logic        score_take;
   logic [13:0] weight;
   logic        rem_ge;
   logic        conv_last;
   logic        hold_done;
   logic        blink_wrap;
   logic [13:0] score_clamped;

   function automatic digits_t msg_text(input logic [1:0] sel);
      digits_t t;
      unique case (sel)
         2'd0:    t = {5'd10, 5'd11, 5'd11, 5'd12};
         2'd1:    t = {5'd31, 5'd13, 5'd14, 5'd12};
         2'd2:    t = {5'd15, 5'd16, 5'd17, 5'd14};
         default: t = '1;
      endcase
      return t;
   endfunction

   // Leading zeros in the upper three digits become blank; ones always shows.
   function automatic digits_t blank_codes(input logic [3:0] d3, input logic [3:0] d2,
                                           input logic [3:0] d1, input logic [3:0] d0);
      digits_t t;
      logic    b3, b2, b1;
      b3 = (d3 == 4'd0);
      b2 = b3 && (d2 == 4'd0);
      b1 = b2 && (d1 == 4'd0);
      t[3] = b3 ? 5'd31 : {1'b0, d3};
      t[2] = b2 ? 5'd31 : {1'b0, d2};
      t[1] = b1 ? 5'd31 : {1'b0, d1};
      t[0] = {1'b0, d0};
      return t;
   endfunction

   // Decode conditions shared by the next-state and datapath logic.
   always_comb begin
      msg_take      = bus.msg_req && (state_q != CONV);
      score_take    = (state_q == IDLE) && bus.score_valid && !bus.msg_req;
      score_clamped = (bus.score > 14'd9999) ? 14'd9999 : bus.score;
      unique case (phase_q)
         PH_THOU: weight = 14'd1000;
         PH_HUND: weight = 14'd100;
         default: weight = 14'd10;
      endcase
      rem_ge     = (rem_q >= weight);
      conv_last  = (state_q == CONV) && (phase_q == PH_TENS) && !rem_ge;
      hold_done  = (hold_q == HW'(HOLD_CYCLES - 1));
      blink_wrap = (blink_q == BW'(BLINK_CYCLES - 1));
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= PH_THOU;
         rem_q   <= '0;
         cnt_q   <= '0;
         d3c_q   <= '0;
         d2c_q   <= '0;
         com_q   <= RESET_DIGITS;
         dig_q   <= RESET_DIGITS;
         msg_q   <= '1;
         vis_q   <= 1'b1;
         hold_q  <= '0;
         blink_q <= '0;
         ack_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         d3c_q   <= d3c_d;
         d2c_q   <= d2c_d;
         com_q   <= com_d;
         dig_q   <= dig_d;
         msg_q   <= msg_d;
         vis_q   <= vis_d;
         hold_q  <= hold_d;
         blink_q <= blink_d;
         ack_q   <= ack_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state selection; messages outrank scores and end a hold early.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.msg_req)
               state_d = (bus.msg_sel == 2'd3) ? IDLE : SHOW_MSG;
            else if (bus.score_valid)
               state_d = CONV;
         end
         CONV: begin
            if (conv_last)
               state_d = IDLE;
         end
         SHOW_MSG: begin
            if (bus.msg_req)
               state_d = (bus.msg_sel == 2'd3) ? IDLE : SHOW_MSG;
            else if (hold_done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values for the current state.
   always_comb begin
      phase_d = phase_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      d3c_d   = d3c_q;
      d2c_d   = d2c_q;
      com_d   = com_q;
      dig_d   = dig_q;
      msg_d   = msg_q;
      vis_d   = vis_q;
      hold_d  = hold_q;
      blink_d = blink_q;
      ack_d   = msg_take;
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);

      if (msg_take) begin
         if (bus.msg_sel == 2'd3) begin
            dig_d = com_q;
         end else begin
            msg_d   = msg_text(bus.msg_sel);
            dig_d   = msg_text(bus.msg_sel);
            vis_d   = 1'b1;
            hold_d  = '0;
            blink_d = '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (score_take) begin
                  rem_d   = score_clamped;
                  cnt_d   = '0;
                  phase_d = PH_THOU;
               end
            end
            CONV: begin
               if (rem_ge) begin
                  rem_d = rem_q - weight;
                  cnt_d = cnt_q + 4'd1;
               end else begin
                  cnt_d = '0;
                  unique case (phase_q)
                     PH_THOU: begin
                        d3c_d   = cnt_q;
                        phase_d = PH_HUND;
                     end
                     PH_HUND: begin
                        d2c_d   = cnt_q;
                        phase_d = PH_TENS;
                     end
                     default: begin
                        // Tens count and ones remainder are folded straight into the commit.
                        com_d   = blank_codes(d3c_q, d2c_q, cnt_q, rem_q[3:0]);
                        dig_d   = blank_codes(d3c_q, d2c_q, cnt_q, rem_q[3:0]);
                        phase_d = PH_THOU;
                     end
                  endcase
               end
            end
            SHOW_MSG: begin
               if (hold_done) begin
                  hold_d  = '0;
                  blink_d = '0;
                  dig_d   = com_q;
               end else begin
                  hold_d = hold_q + HW'(1);
                  if (blink_wrap) begin
                     blink_d = '0;
                     vis_d   = !vis_q;
                     dig_d   = vis_q ? '1 : msg_q;
                  end else begin
                     blink_d = blink_q + BW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.score_ready = ready_q;
   assign bus.msg_ack     = ack_q;
   assign bus.busy        = busy_q;
   assign bus.digit3      = dig_q[3];
   assign bus.digit2      = dig_q[2];
   assign bus.digit1      = dig_q[1];
   assign bus.digit0      = dig_q[0];

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl: a vector table of scores with
// hand-computed digits and conversion lengths, plus hand-written message,
// priority, restart, clear and reset sequences.
module tb_seg7_display_ctrl;
   localparam int unsigned HOLD  = 20;
   localparam int unsigned BLINK = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_display_ctrl_if bus();

   seg7_display_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [13:0] score;
      logic [19:0] exp;
      int unsigned n;
   } vec_t;

   vec_t        vt[10];
   int          checks = 0;
   int          errors = 0;
   logic [19:0] prev;
   logic [19:0] good_t, end_t, burn_t, blank_t;
   int unsigned k;

   function automatic logic [19:0] dg(input int unsigned a, input int unsigned b,
                                      input int unsigned c, input int unsigned d);
      return {a[4:0], b[4:0], c[4:0], d[4:0]};
   endfunction

   function automatic logic [19:0] disp();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Steps through CONV until score_ready returns; k counts CONV cycles after the accept edge.
   task automatic conv_wait(input string name, input logic [19:0] held, output int unsigned kk);
      kk = 0;
      while (bus.score_ready !== 1'b1 && kk < 100) begin
         chk({name, " hold"}, {12'd0, disp()}, {12'd0, held});
         chk({name, " ack"}, {31'd0, bus.msg_ack}, 32'd0);
         chk({name, " busy"}, {31'd0, bus.busy}, 32'd1);
         step();
         kk++;
      end
      if (kk >= 100) chk({name, " timeout"}, {31'd0, bus.score_ready}, 32'd1);
   endtask

   task automatic msg_accept(input string name, input logic [1:0] sel, input logic [19:0] exp);
      bus.msg_req = 1'b1;
      bus.msg_sel = sel;
      step();
      bus.msg_req = 1'b0;
      chk({name, " ack"}, {31'd0, bus.msg_ack}, 32'd1);
      chk({name, " digits"}, {12'd0, disp()}, {12'd0, exp});
      chk({name, " busy"}, {31'd0, bus.busy}, (sel == 2'd3) ? 32'd0 : 32'd1);
      chk({name, " ready"}, {31'd0, bus.score_ready}, (sel == 2'd3) ? 32'd1 : 32'd0);
   endtask

   // After an accept edge E: blink pattern through E+HOLD-1, committed score at E+HOLD.
   task automatic msg_hold(input string name, input logic [19:0] text, input logic [19:0] committed);
      logic [19:0] e;
      for (int c = 1; c < int'(HOLD); c++) begin
         step();
         e = (((c / int'(BLINK)) % 2) == 0) ? text : blank_t;
         chk($sformatf("%s c%0d digits", name, c), {12'd0, disp()}, {12'd0, e});
         chk($sformatf("%s c%0d busy", name, c), {31'd0, bus.busy}, 32'd1);
         if (c == 1) chk({name, " ack one cycle"}, {31'd0, bus.msg_ack}, 32'd0);
      end
      step();
      chk({name, " restore"}, {12'd0, disp()}, {12'd0, committed});
      chk({name, " end busy"}, {31'd0, bus.busy}, 32'd0);
      chk({name, " end ready"}, {31'd0, bus.score_ready}, 32'd1);
   endtask

   initial begin
      good_t  = dg(10, 11, 11, 12);
      end_t   = dg(31, 13, 14, 12);
      burn_t  = dg(15, 16, 17, 14);
      blank_t = dg(31, 31, 31, 31);

      vt[0] = '{score: 14'd305,   exp: dg(31, 3, 0, 5),    n: 6};
      vt[1] = '{score: 14'd12000, exp: dg(9, 9, 9, 9),     n: 30};
      vt[2] = '{score: 14'd0,     exp: dg(31, 31, 31, 0),  n: 3};
      vt[3] = '{score: 14'd7,     exp: dg(31, 31, 31, 7),  n: 3};
      vt[4] = '{score: 14'd10,    exp: dg(31, 31, 1, 0),   n: 4};
      vt[5] = '{score: 14'd100,   exp: dg(31, 1, 0, 0),    n: 4};
      vt[6] = '{score: 14'd1000,  exp: dg(1, 0, 0, 0),     n: 4};
      vt[7] = '{score: 14'd9999,  exp: dg(9, 9, 9, 9),     n: 30};
      vt[8] = '{score: 14'd42,    exp: dg(31, 31, 4, 2),   n: 7};
      vt[9] = '{score: 14'd305,   exp: dg(31, 3, 0, 5),    n: 6};

      rst             = 1'b1;
      bus.score_valid = 1'b0;
      bus.score       = '0;
      bus.msg_req     = 1'b0;
      bus.msg_sel     = '0;
      step();
      step();
      chk("reset digits", {12'd0, disp()}, {12'd0, dg(31, 31, 31, 0)});
      chk("reset ready", {31'd0, bus.score_ready}, 32'd1);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset ack", {31'd0, bus.msg_ack}, 32'd0);
      rst = 1'b0;
      step();

      // Score conversion table
      prev = dg(31, 31, 31, 0);
      for (int i = 0; i < 10; i++) begin
         bus.score       = vt[i].score;
         bus.score_valid = 1'b1;
         step();
         bus.score_valid = 1'b0;
         conv_wait($sformatf("vec%0d", i), prev, k);
         chk($sformatf("vec%0d cycles", i), k, vt[i].n);
         chk($sformatf("vec%0d digits", i), {12'd0, disp()}, {12'd0, vt[i].exp});
         chk($sformatf("vec%0d busy", i), {31'd0, bus.busy}, 32'd0);
         prev = vt[i].exp;
      end

      // Blinking "burn" for the full hold time
      msg_accept("burn", 2'd2, burn_t);
      msg_hold("burn", burn_t, prev);

      // Message and score offered together: message first, score waits
      bus.score       = 14'd42;
      bus.score_valid = 1'b1;
      msg_accept("prio good", 2'd0, good_t);
      msg_hold("prio good", good_t, prev);
      step();
      bus.score_valid = 1'b0;
      bus.msg_req     = 1'b1;
      bus.msg_sel     = 2'd1;
      conv_wait("pending 42", prev, k);
      chk("pending 42 cycles", k, 32'd7);
      chk("pending 42 digits", {12'd0, disp()}, {12'd0, dg(31, 31, 4, 2)});
      chk("no ack at commit", {31'd0, bus.msg_ack}, 32'd0);
      prev = dg(31, 31, 4, 2);
      step();
      bus.msg_req = 1'b0;
      chk("late End ack", {31'd0, bus.msg_ack}, 32'd1);
      chk("late End digits", {12'd0, disp()}, {12'd0, end_t});

      // New message mid-hold restarts timing
      for (int c = 0; c < 10; c++) step();
      msg_accept("restart good", 2'd0, good_t);
      msg_hold("restart good", good_t, prev);

      // Clear message ends the hold immediately
      msg_accept("End again", 2'd1, end_t);
      step();
      step();
      msg_accept("clear", 2'd3, prev);

      // Reset mid-conversion discards partial and committed score
      bus.score       = 14'd9876;
      bus.score_valid = 1'b1;
      step();
      bus.score_valid = 1'b0;
      for (int c = 0; c < 5; c++) step();
      chk("9876 busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst digits", {12'd0, disp()}, {12'd0, dg(31, 31, 31, 0)});
      chk("midrst ready", {31'd0, bus.score_ready}, 32'd1);
      chk("midrst busy", {31'd0, bus.busy}, 32'd0);
      for (int c = 0; c < 30; c++) step();
      chk("midrst stays", {12'd0, disp()}, {12'd0, dg(31, 31, 31, 0)});
      msg_accept("post rst good", 2'd0, good_t);
      msg_accept("post rst clear", 2'd3, dg(31, 31, 31, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Sequencer that owns the four-digit seven-segment display in front of the 5-bit code decoders (codes 0–9 digits, 10 g, 11 o, 12 d, 13 E, 14 n, 15 b, 16 u, 17 r, any other code blank). It accepts binary scores, converts them to decimal digit codes with an iterative subtract FSM, and overlays blinking text messages ("good", "End", "burn") for a fixed hold time before restoring the score. One instance drives four decoder instances, one per digit.

## Interface
- HOLD_CYCLES, 50_000_000: total cycles a message stays on the display.
- BLINK_CYCLES, 12_500_000: half-period of the message blink.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- score_valid  in  1  score offer; held by the source until accepted.
- score  in  14  unsigned binary score; values above 9999 are clamped to 9999.
- score_ready  out  1  high when a score can be accepted (state IDLE only).
- msg_req  in  1  message request; held by the source until acknowledged.
- msg_sel  in  2  0 good, 1 End, 2 burn, 3 clear message.
- msg_ack  out  1  one-cycle pulse on the edge a message request is accepted.
- busy  out  1  high in CONV or SHOW_MSG.
- digit3, digit2, digit1, digit0  out  5 each  decoder codes, digit3 leftmost.

## Operation
- States: IDLE, CONV, SHOW_MSG. All outputs are registered.
- Reset: state IDLE; digits {31,31,31,0} (shows "0"); committed score digits = same; score_ready 1; msg_ack 0; busy 0; all counters 0.
- IDLE: display shows committed score. msg_req has priority over score_valid when both are high in the same cycle; the score stays pending (score_ready drops when the FSM leaves IDLE).
- Score accept (IDLE, score_valid & !msg_req): latch min(score, 9999) into a 14-bit remainder, phase = thousands, count = 0, go to CONV.
- CONV, one step per cycle: if remainder >= weight (1000/100/10 by phase), subtract weight and increment count; otherwise store count as that phase's digit, clear count, advance phase. On exiting the tens phase, ones digit = remainder; commit all four digits atomically and return to IDLE. Cycles in CONV: N = d3 + d2 + d1 + 3.
- Leading-zero blanking at commit: leading zeros among digit3..digit1 become 31; digit0 always shows its digit (score 0 → {31,31,31,0}).
- Display holds the previous committed value throughout CONV; msg_req is not acknowledged in CONV and stays pending.
- Message accept (IDLE or SHOW_MSG, msg_req high): msg_ack pulses; sel 0 → {10,11,11,12}; sel 1 → {31,13,14,12}; sel 2 → {15,16,17,14}; hold and blink counters cleared; go to SHOW_MSG. sel 3 → go/stay IDLE, restore committed score immediately.
- A new message in SHOW_MSG restarts hold and blink timing with the new text.
- SHOW_MSG blink: message visible for BLINK_CYCLES cycles, all-31 for BLINK_CYCLES, repeating. After HOLD_CYCLES cycles return to IDLE and show committed score, regardless of blink phase.
- Scores arriving during SHOW_MSG wait (score_ready 0) and convert after the return to IDLE.

## Timing
- Score sampled on edge E → CONV for N cycles → digits update and score_ready rises on edge E+N+1... precisely: first CONV cycle follows E; digits change on the edge ending the Nth CONV cycle.
- Message accepted on edge E: msg_ack high during cycle E..E+1, digits show message from E, busy high from E.
- Blank phase begins on edge E+BLINK_CYCLES; score restored on edge E+HOLD_CYCLES.
- rst mid-CONV or mid-SHOW_MSG: on the reset edge all state returns to reset values; the partially converted score and committed score are discarded.
- Counters sized to hold HOLD_CYCLES-1 and BLINK_CYCLES-1; no wrap occurs within one message.

## Test plan
- Reset → digits {31,31,31,0}, score_ready 1, busy 0, msg_ack 0.
- score 305 offered in IDLE → 6 CONV cycles, then digits {31,3,0,5}, score_ready back to 1.
- score 12000 → clamped, 30 CONV cycles, digits {9,9,9,9}; score 0 → 3 cycles, {31,31,31,0}.
- HOLD_CYCLES=20, BLINK_CYCLES=4, msg_sel 2 → msg_ack one cycle, {15,16,17,14} 4 cycles, blank 4 cycles, …, committed score back at cycle 20.
- msg_req (sel 0) and score_valid (42) same IDLE cycle → "good" shown first; after hold, 42 converts to {31,31,4,2}; msg_req during CONV acknowledged only after commit.
- SHOW_MSG with sel 1, then sel 3 request → immediate score restore; rst asserted mid-CONV of 9876 → {31,31,31,0} next edge.
